// File: rtl/rob_commit.sv
// Eight-entry reorder buffer: allocation at the tail, CDB writeback by tag, and
// in-order retirement at the head with register write, store release or branch flush.
module rob_commit #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [PTR_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              commit_valid,
  output logic [PTR_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_value,
  output logic              commit_regwe,
  output logic              commit_memwe,
  output logic              flush,
  output logic [3:0]        flush_target,
  output logic              rob_empty
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [3:0] FUNC_LAST_ALU = 4'b0100;
  localparam logic [3:0] FUNC_STORE    = 4'b0101;
  localparam logic [3:0] FUNC_BEQ      = 4'b0110;
  localparam logic [3:0] FUNC_BNEQ     = 4'b0111;

  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [PTR_W:0]    count_reg, count_next;

  logic [DEPTH-1:0]  valid_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic [3:0]        func_arr  [DEPTH];
  logic [REG_W-1:0]  rd_arr    [DEPTH];
  logic [DATA_W-1:0] value_arr [DEPTH];

  logic              do_alloc;
  logic              do_cdb;
  logic              do_commit;
  logic              do_flush;
  logic [3:0]        head_func;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_value;
  logic              head_is_branch;

  logic              commit_valid_reg;
  logic [PTR_W-1:0]  commit_tag_reg;
  logic [REG_W-1:0]  commit_rd_reg;
  logic [DATA_W-1:0] commit_value_reg;
  logic              commit_regwe_reg;
  logic              commit_memwe_reg;
  logic              flush_reg;
  logic [3:0]        flush_target_reg;

  // Admission is based purely on the registered count, so a retire in the
  // same cycle never frees a slot for a simultaneous request.
  assign alloc_ready = (count_reg < CNT_FULL);
  assign alloc_tag   = tail_reg;
  assign rob_empty   = (count_reg == '0);

  always_comb begin
    head_func      = func_arr[head_reg];
    head_rd        = rd_arr[head_reg];
    head_value     = value_arr[head_reg];
    head_is_branch = (head_func == FUNC_BEQ) || (head_func == FUNC_BNEQ);
    do_alloc       = alloc_valid && alloc_ready;
    do_commit      = valid_vec[head_reg] && ready_vec[head_reg];
    do_flush       = do_commit && head_is_branch && head_value[0];
    do_cdb         = cdb_valid && valid_vec[cdb_tag] && !ready_vec[cdb_tag];
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (do_flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (do_alloc)  tail_next = tail_reg + PTR_ONE;
      if (do_commit) head_next = head_reg + PTR_ONE;
      case ({do_alloc, do_commit})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Each entry owns its own state; a taken branch at the head wipes them all.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic              valid_reg;
      logic              ready_reg;
      logic [3:0]        func_reg;
      logic [REG_W-1:0]  rd_reg;
      logic [DATA_W-1:0] value_reg;
      logic              alloc_hit;
      logic              cdb_hit;
      logic              commit_hit;

      assign alloc_hit  = do_alloc  && (tail_reg == PTR_W'(gi));
      assign cdb_hit    = do_cdb    && (cdb_tag  == PTR_W'(gi));
      assign commit_hit = do_commit && (head_reg == PTR_W'(gi));

      always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
          func_reg  <= '0;
          rd_reg    <= '0;
          value_reg <= '0;
        end else if (do_flush) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
        end else if (alloc_hit) begin
          valid_reg <= 1'b1;
          ready_reg <= 1'b0;
          func_reg  <= alloc_func;
          rd_reg    <= alloc_rd;
        end else if (cdb_hit) begin
          ready_reg <= 1'b1;
          value_reg <= cdb_value;
        end else if (commit_hit) begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign ready_vec[gi] = ready_reg;
      assign func_arr[gi]  = func_reg;
      assign rd_arr[gi]    = rd_reg;
      assign value_arr[gi] = value_reg;
    end
  endgenerate

  // Strobes pulse for one cycle; data fields hold the last retired entry.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      commit_valid_reg <= 1'b0;
      commit_tag_reg   <= '0;
      commit_rd_reg    <= '0;
      commit_value_reg <= '0;
      commit_regwe_reg <= 1'b0;
      commit_memwe_reg <= 1'b0;
      flush_reg        <= 1'b0;
      flush_target_reg <= '0;
    end else begin
      commit_valid_reg <= do_commit;
      commit_regwe_reg <= do_commit && (head_func <= FUNC_LAST_ALU);
      commit_memwe_reg <= do_commit && (head_func == FUNC_STORE);
      flush_reg        <= do_flush;
      if (do_commit) begin
        commit_tag_reg   <= head_reg;
        commit_rd_reg    <= head_rd;
        commit_value_reg <= head_value;
      end
      if (do_flush) flush_target_reg <= 4'(head_rd);
    end
  end

  assign commit_valid = commit_valid_reg;
  assign commit_tag   = commit_tag_reg;
  assign commit_rd    = commit_rd_reg;
  assign commit_value = commit_value_reg;
  assign commit_regwe = commit_regwe_reg;
  assign commit_memwe = commit_memwe_reg;
  assign flush        = flush_reg;
  assign flush_target = flush_target_reg;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: allocation, out-of-order writeback, in-order
// retirement, full/wrap behaviour, branch flush and store/branch decode.
module tb_rob_commit;
  localparam int PTR_W  = 3;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  logic              clk1 = 1'b0;
  logic              rst  = 1'b1;
  logic              alloc_valid = 1'b0;
  logic [3:0]        alloc_func  = '0;
  logic [REG_W-1:0]  alloc_rd    = '0;
  logic              alloc_ready;
  logic [PTR_W-1:0]  alloc_tag;
  logic              cdb_valid = 1'b0;
  logic [PTR_W-1:0]  cdb_tag   = '0;
  logic [DATA_W-1:0] cdb_value = '0;
  logic              commit_valid;
  logic [PTR_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_value;
  logic              commit_regwe;
  logic              commit_memwe;
  logic              flush;
  logic [3:0]        flush_target;
  logic              rob_empty;

  int checks = 0;
  int errors = 0;

  rob_commit #(.DEPTH(8), .PTR_W(PTR_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_regwe(commit_regwe),
    .commit_memwe(commit_memwe), .flush(flush), .flush_target(flush_target),
    .rob_empty(rob_empty)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic alloc(input logic [3:0] f, input logic [3:0] rd);
    $display("alloc   func=%b rd=%0d tag=%0d ready=%0b", f, rd, alloc_tag, alloc_ready);
    alloc_valid = 1'b1;
    alloc_func  = f;
    alloc_rd    = rd;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [15:0] val);
    $display("cdb     tag=%0d value=0x%04h", tag, val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic do_reset();
    $display("reset");
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_rob_empty", rob_empty, 1);
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_regwe", commit_regwe, 0);
    check("rst_memwe", commit_memwe, 0);
    check("rst_flush", flush, 0);
    rst = 1'b0;

    // Single add retires one edge after its CDB write
    alloc(4'b0000, 4'd3);
    check("t2_not_empty", rob_empty, 0);
    cdb(3'd0, 16'h00A5);
    check("t2_no_early_commit", commit_valid, 0);
    tick();
    $display("commit  tag=%0d rd=%0d value=0x%04h", commit_tag, commit_rd, commit_value);
    check("t2_commit_valid", commit_valid, 1);
    check("t2_regwe", commit_regwe, 1);
    check("t2_rd", commit_rd, 3);
    check("t2_value", commit_value, 16'h00A5);
    check("t2_tag", commit_tag, 0);
    check("t2_empty_after", rob_empty, 1);
    tick();
    check("t2_strobe_one_cycle", commit_valid, 0);
    check("t2_value_holds", commit_value, 16'h00A5);

    // Reset mid-run with three live entries, head already ready
    alloc(4'b0001, 4'd1);
    alloc(4'b0001, 4'd2);
    alloc(4'b0001, 4'd4);
    cdb(3'd1, 16'h0042);
    rst = 1'b1;
    #1;
    check("mid_rst_empty", rob_empty, 1);
    check("mid_rst_ready", alloc_ready, 1);
    check("mid_rst_tag", alloc_tag, 0);
    tick();
    check("mid_rst_no_commit", commit_valid, 0);
    rst = 1'b0;

    // Out-of-order writeback, in-order retirement
    alloc(4'b0000, 4'd1);
    alloc(4'b0000, 4'd2);
    alloc(4'b0000, 4'd3);
    cdb(3'd2, 16'h0022);
    tick();
    check("t3_wait_tag2", commit_valid, 0);
    cdb(3'd1, 16'h0011);
    tick();
    check("t3_wait_tag1", commit_valid, 0);
    cdb(3'd0, 16'h0010);
    check("t3_wait_tag0", commit_valid, 0);
    tick();
    check("t3_c0_valid", commit_valid, 1);
    check("t3_c0_tag", commit_tag, 0);
    check("t3_c0_value", commit_value, 16'h0010);
    tick();
    check("t3_c1_valid", commit_valid, 1);
    check("t3_c1_tag", commit_tag, 1);
    check("t3_c1_value", commit_value, 16'h0011);
    tick();
    check("t3_c2_valid", commit_valid, 1);
    check("t3_c2_tag", commit_tag, 2);
    check("t3_c2_rd", commit_rd, 3);
    tick();
    check("t3_done", commit_valid, 0);
    check("t3_empty", rob_empty, 1);

    // Full ROB, refused alloc, wrap, ignored CDB writes
    do_reset();
    for (int i = 0; i < 8; i++) alloc(4'b0000, 4'(i));
    check("t4_full_ready", alloc_ready, 0);
    check("t4_full_tag", alloc_tag, 0);
    alloc(4'b0000, 4'hF);
    check("t4_9th_ready", alloc_ready, 0);
    check("t4_9th_tag", alloc_tag, 0);
    check("t4_9th_no_commit", commit_valid, 0);
    cdb(3'd1, 16'h0111);
    cdb(3'd1, 16'h0999);
    cdb(3'd0, 16'h0100);
    alloc(4'b0000, 4'hD);
    check("t4_c0_valid", commit_valid, 1);
    check("t4_c0_tag", commit_tag, 0);
    check("t4_c0_value", commit_value, 16'h0100);
    check("t4_ready_again", alloc_ready, 1);
    check("t4_refused_tail", alloc_tag, 0);
    alloc(4'b0000, 4'hE);
    check("t4_c1_tag", commit_tag, 1);
    check("t4_c1_value", commit_value, 16'h0111);
    check("t4_wrap_tag", alloc_tag, 1);
    check("t4_count7_ready", alloc_ready, 1);
    cdb(3'd1, 16'h0777);
    check("t4_unalloc_no_commit", commit_valid, 0);
    check("t4_value_holds", commit_value, 16'h0111);
    tick();
    check("t4_head2_waits", commit_valid, 0);

    // Taken branch flushes younger work; same-cycle alloc dropped
    do_reset();
    alloc(4'b0110, 4'd9);
    alloc(4'b0000, 4'd5);
    cdb(3'd1, 16'h0055);
    cdb(3'd0, 16'h0001);
    alloc(4'b0000, 4'd7);
    $display("flush   flush=%0b target=%0d", flush, flush_target);
    check("t5_flush", flush, 1);
    check("t5_target", flush_target, 9);
    check("t5_commit_valid", commit_valid, 1);
    check("t5_regwe", commit_regwe, 0);
    check("t5_empty", rob_empty, 1);
    check("t5_tail0", alloc_tag, 0);
    tick();
    check("t5_flush_pulse", flush, 0);
    check("t5_tag1_squashed", commit_valid, 0);
    tick();
    check("t5_still_quiet", commit_valid, 0);
    check("t5_still_empty", rob_empty, 1);

    // Store, not-taken branch, undefined opcode
    alloc(4'b0101, 4'd2);
    cdb(3'd0, 16'h1234);
    tick();
    check("t6_st_valid", commit_valid, 1);
    check("t6_st_memwe", commit_memwe, 1);
    check("t6_st_regwe", commit_regwe, 0);
    check("t6_st_value", commit_value, 16'h1234);
    tick();
    check("t6_memwe_pulse", commit_memwe, 0);
    alloc(4'b0111, 4'd3);
    cdb(3'd1, 16'h0000);
    tick();
    check("t6_bn_valid", commit_valid, 1);
    check("t6_bn_flush", flush, 0);
    check("t6_bn_regwe", commit_regwe, 0);
    check("t6_bn_tag", commit_tag, 1);
    alloc(4'b1000, 4'd6);
    cdb(3'd2, 16'h0001);
    tick();
    check("t6_op8_valid", commit_valid, 1);
    check("t6_op8_regwe", commit_regwe, 0);
    check("t6_op8_memwe", commit_memwe, 0);
    check("t6_op8_flush", flush, 0);
    check("t6_op8_rd", commit_rd, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
